// File: rtl/fft_frame_feeder_pkg.sv
// +----------------------------------------------------------------------------+
// | fft_frame_feeder_pkg : shared constants and TX state encoding               |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

package fft_frame_feeder_pkg;

    localparam int c_num_banks = 2;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_prime = 2'd1;
    localparam logic [1:0] c_st_burst = 2'd2;

    function automatic int nfft_of(input int size_buffer);
        return 1 << size_buffer;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_frame_feeder_if.sv
// +----------------------------------------------------------------------------+
// | fft_frame_feeder_if : sample-input, FFT-output and status bundle            |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

interface fft_frame_feeder_if #(
    parameter int DATA_FFT_SIZE = 16
);
    logic                     in_valid;
    logic [DATA_FFT_SIZE-1:0] in_data_i;
    logic [DATA_FFT_SIZE-1:0] in_data_q;
    logic                     in_ready;
    logic                     fft_wayt_data;
    logic                     fft_valid;
    logic [DATA_FFT_SIZE-1:0] fft_data_i;
    logic [DATA_FFT_SIZE-1:0] fft_data_q;
    logic [1:0]               frames_ready;
    logic                     overflow;
    logic                     ovf_clr;

    // Feeder side
    modport master (
        input  in_valid, in_data_i, in_data_q, fft_wayt_data, ovf_clr,
        output in_ready, fft_valid, fft_data_i, fft_data_q, frames_ready, overflow
    );

    // Sample source / FFT / control side
    modport slave (
        output in_valid, in_data_i, in_data_q, fft_wayt_data, ovf_clr,
        input  in_ready, fft_valid, fft_data_i, fft_data_q, frames_ready, overflow
    );
endinterface

`default_nettype wire

// File: rtl/fft_feeder_dpram.sv
// +----------------------------------------------------------------------------+
// | fft_feeder_dpram : simple dual-port RAM, one write port, registered read    |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module fft_feeder_dpram #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 9
) (
    input  wire logic              clk,
    input  wire logic              i_wr_en,
    input  wire logic [ADDR_W-1:0] i_wr_addr,
    input  wire logic [WIDTH-1:0]  i_wr_data,
    input  wire logic [ADDR_W-1:0] i_rd_addr,
    output logic      [WIDTH-1:0]  o_rd_data
);
    logic [WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/fft_frame_feeder.sv
// +----------------------------------------------------------------------------+
// | fft_frame_feeder : ping-pong frame store feeding the FFT one burst per frame|
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module fft_frame_feeder
    import fft_frame_feeder_pkg::*;
#(
    parameter int SIZE_BUFFER   = 8,
    parameter int DATA_FFT_SIZE = 16
) (
    input wire logic            clk,
    input wire logic            reset,
    fft_frame_feeder_if.master  bus
);
    localparam int NFFT     = nfft_of(SIZE_BUFFER);
    localparam int c_ram_aw = SIZE_BUFFER + 1;
    localparam int c_ram_w  = 2 * DATA_FFT_SIZE;
    localparam logic [SIZE_BUFFER-1:0] c_last_addr = SIZE_BUFFER'(NFFT - 1);
    localparam logic [SIZE_BUFFER-1:0] c_addr_one  = SIZE_BUFFER'(1);

    logic [c_num_banks-1:0]   r_full;
    logic                     r_wr_bank;
    logic [SIZE_BUFFER-1:0]   r_wr_addr;
    logic                     r_rd_bank;
    logic [SIZE_BUFFER-1:0]   r_rd_addr;
    logic [1:0]               r_state;
    logic                     r_overflow;
    logic                     r_fft_valid;
    logic [DATA_FFT_SIZE-1:0] r_fft_data_i;
    logic [DATA_FFT_SIZE-1:0] r_fft_data_q;

    logic                     w_in_ready;
    logic                     w_wr_en;
    logic                     w_wr_last;
    logic                     w_ovf_evt;
    logic                     w_start;
    logic                     w_last;
    logic [1:0]               w_state_next;
    logic                     w_valid_d;
    logic                     w_release;
    logic [SIZE_BUFFER-1:0]   w_rd_addr_d;
    logic [c_num_banks-1:0]   w_full_set;
    logic [c_num_banks-1:0]   w_full_clr;
    logic [c_ram_w-1:0]       w_ram_q;

    // ---------------- write side ----------------
    assign w_in_ready = ~r_full[r_wr_bank];
    assign w_wr_en    = bus.in_valid & w_in_ready;
    assign w_wr_last  = w_wr_en & (r_wr_addr == c_last_addr);
    assign w_ovf_evt  = bus.in_valid & ~w_in_ready;

    // Set and clear always target different banks: a bank being written is empty.
    always_comb begin
        w_full_set = '0;
        w_full_clr = '0;
        w_full_set[r_wr_bank] = w_wr_last;
        w_full_clr[r_rd_bank] = w_release;
    end

    // ---------------- TX FSM ----------------
    assign w_start = r_full[r_rd_bank] & bus.fft_wayt_data;
    // During BURST rd_addr runs one ahead of the sample on the RAM output,
    // so it has wrapped to zero exactly when the last sample is presented.
    assign w_last  = (r_state == c_st_burst) && (r_rd_addr == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (w_start) w_state_next = c_st_prime;
            c_st_prime: w_state_next = c_st_burst;
            c_st_burst: if (w_last) w_state_next = c_st_idle;
            default:    w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_valid_d   = (r_state == c_st_burst);
        w_release   = w_last;
        w_rd_addr_d = '0;
        if ((r_state == c_st_prime) || ((r_state == c_st_burst) && !w_last)) begin
            w_rd_addr_d = r_rd_addr + c_addr_one;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_full       <= '0;
            r_wr_bank    <= 1'b0;
            r_wr_addr    <= '0;
            r_rd_bank    <= 1'b0;
            r_rd_addr    <= '0;
            r_overflow   <= 1'b0;
            r_fft_valid  <= 1'b0;
            r_fft_data_i <= '0;
            r_fft_data_q <= '0;
        end else begin
            r_full <= (r_full | w_full_set) & ~w_full_clr;
            if (w_wr_en) begin
                r_wr_addr <= r_wr_addr + c_addr_one;
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
            r_rd_addr <= w_rd_addr_d;
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_overflow <= 1'b0;
            end
            r_fft_valid  <= w_valid_d;
            r_fft_data_i <= w_valid_d ? w_ram_q[c_ram_w-1:DATA_FFT_SIZE] : '0;
            r_fft_data_q <= w_valid_d ? w_ram_q[DATA_FFT_SIZE-1:0]       : '0;
        end
    end

    fft_feeder_dpram #(
        .WIDTH  (c_ram_w),
        .ADDR_W (c_ram_aw)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr ({r_wr_bank, r_wr_addr}),
        .i_wr_data ({bus.in_data_i, bus.in_data_q}),
        .i_rd_addr ({r_rd_bank, r_rd_addr}),
        .o_rd_data (w_ram_q)
    );

    assign bus.in_ready     = w_in_ready;
    assign bus.fft_valid    = r_fft_valid;
    assign bus.fft_data_i   = r_fft_data_i;
    assign bus.fft_data_q   = r_fft_data_q;
    assign bus.frames_ready = {1'b0, r_full[0]} + {1'b0, r_full[1]};
    assign bus.overflow     = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_feeder.sv
// +----------------------------------------------------------------------------+
// | tb_fft_frame_feeder : directed scoreboard bench for fft_frame_feeder        |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_fft_frame_feeder;
    localparam int SB = 8;
    localparam int DW = 16;
    localparam int N  = 256;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fft_frame_feeder_if #(.DATA_FFT_SIZE(DW)) bus();

    fft_frame_feeder #(
        .SIZE_BUFFER   (SB),
        .DATA_FFT_SIZE (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    int          bursts[$];
    int          run_cnt = 0;
    int          valid_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard for each valid beat and records burst lengths.
    always @(negedge clk) begin
        if (bus.fft_valid === 1'b1) begin
            run_cnt++;
            valid_total++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underflow: observed data %0h expected no beat",
                       {bus.fft_data_i, bus.fft_data_q});
            end else begin
                chk("burst_data", {bus.fft_data_i, bus.fft_data_q}, sb.pop_front());
            end
        end else if (run_cnt != 0) begin
            bursts.push_back(run_cnt);
            run_cnt = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] i, input logic [15:0] q, input logic exp_acc);
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_acc});
        bus.in_valid  = 1'b1;
        bus.in_data_i = i;
        bus.in_data_q = q;
        if (exp_acc) sb.push_back({i, q});
        step();
        bus.in_valid  = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] seed);
        for (int k = 0; k < N; k++) begin
            send(16'(k) + seed, 16'(N - 1 - k) ^ seed, 1'b1);
        end
    endtask

    task automatic wait_bursts(input int n, input int budget, input string tag);
        int c = 0;
        while (bursts.size() < n && c < budget) begin
            step();
            c++;
        end
        chk({tag, "_burst_seen"}, {31'd0, bursts.size() >= n}, 32'd1);
        while (bursts.size() > 0) begin
            chk({tag, "_burst_len"}, bursts.pop_front(), N);
        end
    endtask

    task automatic wait_run(input int target, input int budget, input string tag);
        int c = 0;
        while (run_cnt < target && c < budget) begin
            step();
            c++;
        end
        chk({tag, "_run_reached"}, {31'd0, run_cnt >= target}, 32'd1);
    endtask

    initial begin
        int v0;
        bus.in_valid      = 1'b0;
        bus.in_data_i     = '0;
        bus.in_data_q     = '0;
        bus.fft_wayt_data = 1'b0;
        bus.ovf_clr       = 1'b0;

        // Reset state
        reset = 1'b0;
        repeat (3) step();
        chk("rst_fft_valid",    {31'd0, bus.fft_valid}, 32'd0);
        chk("rst_fft_data_i",   {16'd0, bus.fft_data_i}, 32'd0);
        chk("rst_fft_data_q",   {16'd0, bus.fft_data_q}, 32'd0);
        chk("rst_in_ready",     {31'd0, bus.in_ready}, 32'd1);
        chk("rst_frames_ready", {30'd0, bus.frames_ready}, 32'd0);
        chk("rst_overflow",     {31'd0, bus.overflow}, 32'd0);
        reset = 1'b1;
        step();

        // Single ramp frame with the FFT waiting
        bus.fft_wayt_data = 1'b1;
        send_frame(16'h0000);
        chk("single_frames_ready_1", {30'd0, bus.frames_ready}, 32'd1);
        wait_bursts(1, 600, "single");
        chk("single_frames_ready_0", {30'd0, bus.frames_ready}, 32'd0);
        chk("single_sb_empty", sb.size(), 32'd0);

        // Hold-off while the FFT is busy
        bus.fft_wayt_data = 1'b0;
        send_frame(16'h1234);
        v0 = valid_total;
        repeat (1000) step();
        chk("hold_no_valid", valid_total, v0);
        chk("hold_frames_ready", {30'd0, bus.frames_ready}, 32'd1);
        chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.fft_wayt_data = 1'b1;
        step();
        chk("hold_lat_edge1", {31'd0, bus.fft_valid}, 32'd0);
        step();
        chk("hold_lat_edge2", {31'd0, bus.fft_valid}, 32'd0);
        step();
        chk("hold_lat_edge3", {31'd0, bus.fft_valid}, 32'd1);
        wait_bursts(1, 600, "hold");

        // Continuous stream of three frames
        for (int f = 0; f < 3; f++) begin
            send_frame(16'(f * 7 + 3));
            repeat (4) step();
        end
        wait_bursts(3, 1500, "cont");
        chk("cont_overflow", {31'd0, bus.overflow}, 32'd0);
        chk("cont_sb_empty", sb.size(), 32'd0);

        // Overflow: both banks fill, five extra samples are dropped
        bus.fft_wayt_data = 1'b0;
        for (int k = 0; k < 2 * N + 5; k++) begin
            send(16'(k) ^ 16'hA5A5, 16'(k * 3), (k < 2 * N) ? 1'b1 : 1'b0);
        end
        chk("ovf_flag", {31'd0, bus.overflow}, 32'd1);
        chk("ovf_frames_ready", {30'd0, bus.frames_ready}, 32'd2);
        chk("ovf_in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        chk("ovf_cleared", {31'd0, bus.overflow}, 32'd0);
        bus.in_valid = 1'b1;
        bus.ovf_clr  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.ovf_clr  = 1'b0;
        chk("ovf_set_wins", {31'd0, bus.overflow}, 32'd1);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        chk("ovf_cleared2", {31'd0, bus.overflow}, 32'd0);
        bus.fft_wayt_data = 1'b1;
        wait_bursts(2, 1200, "ovf");
        chk("ovf_sb_empty", sb.size(), 32'd0);
        chk("ovf_frames_ready_0", {30'd0, bus.frames_ready}, 32'd0);

        // fft_wayt_data dropped mid-burst
        send_frame(16'h0055);
        wait_run(10, 400, "drop");
        bus.fft_wayt_data = 1'b0;
        wait_bursts(1, 600, "drop");
        chk("drop_sb_empty", sb.size(), 32'd0);
        bus.fft_wayt_data = 1'b1;

        // Reset in the middle of a burst
        send_frame(16'h0077);
        wait_run(100, 400, "rstmid");
        reset = 1'b0;
        step();
        chk("rstmid_fft_valid", {31'd0, bus.fft_valid}, 32'd0);
        chk("rstmid_frames_ready", {30'd0, bus.frames_ready}, 32'd0);
        chk("rstmid_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rstmid_overflow", {31'd0, bus.overflow}, 32'd0);
        reset = 1'b1;
        repeat (3) step();
        sb.delete();
        bursts.delete();
        send_frame(16'h0099);
        wait_bursts(1, 600, "post_rst");
        chk("post_rst_sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
